frequency_meter: RTL and testbench
==================================

# frequency_meter

Measures the rate of an external or divided clock-like signal by counting its rising edges over a fixed gate window of system clocks. Each window's count is reported in binary and, optionally, as packed BCD digits for the seven-segment display path. It sits between any slow signal source, such as a divided clock or an external pin, and the display driver. It is the measuring counterpart to the clock-division logic.

## Interface
- `GATE_CYCLES`, default 100000000: system clocks per gate window; must be > `COUNT_WIDTH` + 1.
- `COUNT_WIDTH`, default 16: width of the edge counter and the binary result.
- `DIGITS`, default 5: BCD digits; 10^`DIGITS` must be > 2^`COUNT_WIDTH` − 1.
- `clock`  in  1  system clock; all logic is on its rising edge.
- `resetN`  in  1  synchronous, active-low reset.
- `measuredSignal`  in  1  asynchronous signal under measurement.
- `count`  out  `COUNT_WIDTH`  rising edges counted in the last completed window, saturating.
- `overflow`  out  1  last completed window saturated.
- `countValid`  out  1  one-cycle pulse when `count`/`overflow` update.
- `bcd`  out  4×`DIGITS`  packed BCD of `count`; digit 0 occupies bits [3:0].
- `bcdValid`  out  1  one-cycle pulse when `bcd` updates.
- `busy`  out  1  BCD conversion in progress.

## Operation
- Synchronizer: `measuredSignal` passes through 2 flip-flops. A third flip-flop holds the previous synchronized value. A rising edge is detected when synchronized = 1 and previous = 0.
- Gate counter: runs 0 … `GATE_CYCLES`−1, then wraps to 0.
- Edge counter: increments on each detected edge and holds at 2^`COUNT_WIDTH`−1. A sticky saturation flag is set on any increment attempted while the counter is full.
- Terminal cycle (gate counter = `GATE_CYCLES`−1):
  - `count` is loaded with the edge counter, plus 1 if an edge is detected this same cycle, saturating.
  - `overflow` is loaded with the saturation flag, including an overflow caused by that same-cycle edge.
  - The edge counter and saturation flag clear to 0.
  - `countValid` pulses.
- An edge detected in the terminal cycle belongs to the closing window, never the new one.
- BCD converter (only when the macro is set), states IDLE and SHIFT:
  - IDLE → SHIFT on `countValid`: latch `count`, clear the scratch BCD, set the shift counter to `COUNT_WIDTH`.
  - SHIFT, once per cycle: add 3 to every scratch digit ≥ 5, then shift left one bit, bringing in the binary MSB.
  - SHIFT → IDLE after the `COUNT_WIDTH`-th shift: copy the scratch BCD to `bcd` and pulse `bcdValid`.
- `busy` = 1 exactly while in SHIFT.
- `countValid` cannot arrive during SHIFT because of the `GATE_CYCLES` constraint. No queuing logic is required.
- Reset (`resetN` = 0 at a clock edge) clears all of the following to 0, at any time including mid-window or mid-conversion:
  - synchronizer flip-flops
  - gate and edge counters
  - `count`, `overflow`, `countValid`
  - `bcd`, `bcdValid`, `busy`
  - the converter state, which returns to IDLE
- All outputs are registered.

## Timing
- Cycle 0 is the first cycle after `resetN` is sampled high. Window k covers cycles k·`GATE_CYCLES` … (k+1)·`GATE_CYCLES`−1.
- `countValid` is high during cycle (k+1)·`GATE_CYCLES` for exactly 1 cycle. `count` holds its value until the next pulse.
- Edge-detect latency: a `measuredSignal` rise set up before edge t is counted at edge t+2.
- Minimum resolvable high and low times are each ≥ 2 `clock` periods. Shorter pulses may be missed.
- `bcdValid` is high exactly `COUNT_WIDTH`+1 cycles after the `countValid` cycle. `busy` is high for the `COUNT_WIDTH` cycles in between.
- `bcd` holds its value until the next `bcdValid` pulse.

## Configuration
- `FREQUENCY_METER_BCD_EN` defined: the BCD converter is built, and `bcd`, `bcdValid` and `busy` behave as specified above.
- Not defined: no converter logic is built, and `bcd`, `bcdValid` and `busy` are tied to 0. Binary `count` behaviour is identical in both cases.

## Test plan
- Period of 10 cycles, `GATE_CYCLES`=100: after the first full window, `count`=10, `overflow`=0, and `countValid` pulses every 100 cycles.
- Saturation with `COUNT_WIDTH`=4: 20 edges in one window → `count`=15, `overflow`=1. A following window with 3 edges → `count`=3, `overflow`=0.
- Terminal-cycle edge: place a detected edge exactly at gate value `GATE_CYCLES`−1 with 4 earlier edges → closing `count`=5, next window starts from 0.
- BCD with the macro set, `COUNT_WIDTH`=16, 12345 edges in the window:
  - `bcd`=0x12345 with `bcdValid` 17 cycles after `countValid`.
  - `busy` high for 16 cycles.
  - Without the macro, `bcd`=0 and `bcdValid`=0 throughout.
- Reset mid-window and mid-conversion: `resetN` low for 1 cycle → all outputs 0 on the next cycle. The first `countValid` after release is `GATE_CYCLES` cycles later and counts only post-reset edges.
- Constant-high and constant-low inputs → `count`=0 every window, `overflow`=0.

Source files
------------

// File: rtl/frequency_meter.sv
// Counts measuredSignal rising edges per GATE_CYCLES window; binary result when the window closes. Optional BCD (FREQUENCY_METER_BCD_EN) follows COUNT_WIDTH+1 cycles later.
// No backpressure: countValid and bcdValid are single-cycle pulses, and results hold until the next pulse.
module frequency_meter #(
   parameter int GATE_CYCLES = 100000000,
   parameter int COUNT_WIDTH = 16,
   parameter int DIGITS      = 5
) (
   input  logic                   clock,
   input  logic                   resetN,
   input  logic                   measuredSignal,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   overflow,
   output logic                   countValid,
   output logic [4*DIGITS-1:0]    bcd,
   output logic                   bcdValid,
   output logic                   busy
);
   localparam int GATE_WIDTH = $clog2(GATE_CYCLES);
   localparam logic [GATE_WIDTH-1:0] GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   logic [1:0]             syncQ;
   logic                   prevQ;
   logic                   risingEdge;
   logic [GATE_WIDTH-1:0]  gateCount;
   logic [COUNT_WIDTH-1:0] edgeCount;
   logic                   saturated;
   logic                   terminal;
   logic                   edgeFull;

   assign risingEdge = syncQ[1] & ~prevQ;
   assign terminal   = (gateCount == GATE_LAST);
   assign edgeFull   = (edgeCount == COUNT_MAX);

   always_ff @(posedge clock) begin
      if (!resetN) begin
         syncQ <= '0;
         prevQ <= 1'b0;
      end else begin
         syncQ <= {syncQ[0], measuredSignal};
         prevQ <= syncQ[1];
      end
   end

   // An edge seen in the terminal cycle is folded into the closing window's result.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         gateCount  <= '0;
         edgeCount  <= '0;
         saturated  <= 1'b0;
         count      <= '0;
         overflow   <= 1'b0;
         countValid <= 1'b0;
      end else begin
         countValid <= 1'b0;
         gateCount  <= terminal ? '0 : gateCount + GATE_WIDTH'(1);
         if (terminal) begin
            count      <= (risingEdge && !edgeFull) ? edgeCount + COUNT_WIDTH'(1) : edgeCount;
            overflow   <= saturated | (risingEdge & edgeFull);
            countValid <= 1'b1;
            edgeCount  <= '0;
            saturated  <= 1'b0;
         end else if (risingEdge) begin
            if (edgeFull) begin
               saturated <= 1'b1;
            end else begin
               edgeCount <= edgeCount + COUNT_WIDTH'(1);
            end
         end
      end
   end

`ifdef FREQUENCY_METER_BCD_EN
   typedef enum logic {IDLE, SHIFT} state_t;
   localparam int SHIFT_WIDTH = $clog2(COUNT_WIDTH + 1);

   state_t                 state;
   state_t                 nextState;
   logic [COUNT_WIDTH-1:0] binary;
   logic [4*DIGITS-1:0]    scratch;
   logic [4*DIGITS-1:0]    adjusted;
   logic [4*DIGITS-1:0]    scratchNext;
   logic [SHIFT_WIDTH-1:0] shiftsLeft;
   logic                   startConv;
   logic                   doShift;
   logic                   lastShift;

   // Double-dabble step: correct each digit before the shift so it carries in decimal.
   always_comb begin
      adjusted = scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch[4*d +: 4] >= 4'd5) begin
            adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
         end
      end
      scratchNext = {adjusted[4*DIGITS-2:0], binary[COUNT_WIDTH-1]};
   end

   always_comb begin
      nextState = state;
      startConv = 1'b0;
      doShift   = 1'b0;
      lastShift = 1'b0;
      case (state)
         IDLE: begin
            if (countValid) begin
               nextState = SHIFT;
               startConv = 1'b1;
            end
         end
         SHIFT: begin
            doShift = 1'b1;
            if (shiftsLeft == SHIFT_WIDTH'(1)) begin
               lastShift = 1'b1;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         binary     <= '0;
         scratch    <= '0;
         shiftsLeft <= '0;
         bcd        <= '0;
         bcdValid   <= 1'b0;
      end else begin
         bcdValid <= lastShift;
         if (startConv) begin
            binary     <= count;
            scratch    <= '0;
            shiftsLeft <= SHIFT_WIDTH'(COUNT_WIDTH);
         end else if (doShift) begin
            binary     <= binary << 1;
            scratch    <= scratchNext;
            shiftsLeft <= shiftsLeft - SHIFT_WIDTH'(1);
         end
         if (lastShift) begin
            bcd <= scratchNext;
         end
      end
   end

   assign busy = (state == SHIFT);
`else
   assign bcd      = '0;
   assign bcdValid = 1'b0;
   assign busy     = 1'b0;
`endif

endmodule

// File: tb/tb_frequency_meter.sv
// Directed bench for frequency_meter: a small-window instance for counting/saturation/reset cases
// and a 16-bit instance for a multi-digit BCD conversion.
module tb_frequency_meter;
   localparam int GATE_A = 100;
   localparam int CW_A   = 4;
   localparam int DIG_A  = 2;
   localparam int GATE_B = 50000;
   localparam int CW_B   = 16;
   localparam int DIG_B  = 5;
`ifdef FREQUENCY_METER_BCD_EN
   localparam bit BCD_ON = 1'b1;
`else
   localparam bit BCD_ON = 1'b0;
`endif

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic rstA, rstB, sigA, sigB;
   logic [CW_A-1:0]    countA;
   logic               overflowA, countValidA, bcdValidA, busyA;
   logic [4*DIG_A-1:0] bcdA;
   logic [CW_B-1:0]    countB;
   logic               overflowB, countValidB, bcdValidB, busyB;
   logic [4*DIG_B-1:0] bcdB;

   frequency_meter #(.GATE_CYCLES(GATE_A), .COUNT_WIDTH(CW_A), .DIGITS(DIG_A)) dutA (
      .clock(clock), .resetN(rstA), .measuredSignal(sigA), .count(countA), .overflow(overflowA),
      .countValid(countValidA), .bcd(bcdA), .bcdValid(bcdValidA), .busy(busyA));

   frequency_meter #(.GATE_CYCLES(GATE_B), .COUNT_WIDTH(CW_B), .DIGITS(DIG_B)) dutB (
      .clock(clock), .resetN(rstB), .measuredSignal(sigB), .count(countB), .overflow(overflowB),
      .countValid(countValidB), .bcd(bcdB), .bcdValid(bcdValidB), .busy(busyB));

   int checks   = 0;
   int failures = 0;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] toBcd(input int v);
      logic [31:0] r;
      int rest;
      r = '0;
      rest = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(rest % 10);
         rest = rest / 10;
      end
      return r;
   endfunction

   // Runs one full window of dutA starting at a countValid sample point; ends at the next one.
   // n pulses of the given spacing from j=0, plus an optional 3-cycle pulse at extraAt.
   task automatic runWindow(input string tag, input int n, input int spacing, input int extraAt,
                            input logic base, input int expCount, input logic expOvf, input int prevCount);
      int   cvEarly = 0, bvAt = -1, bvCnt = 0, busyCnt = 0, holdBad = 0;
      logic pulse;
      for (int j = 0; j < GATE_A; j++) begin
         pulse = (j < n * spacing) && ((j % spacing) < spacing / 2);
         if (extraAt >= 0 && j >= extraAt && j <= extraAt + 2) pulse = 1'b1;
         sigA = base ^ pulse;
         tick();
         if (j < GATE_A - 1) begin
            if (countValidA) cvEarly++;
            if (32'(countA) !== 32'(prevCount)) holdBad++;
         end
         if (bcdValidA) begin
            bvCnt++;
            if (bvAt < 0) bvAt = j;
         end
         if (busyA) busyCnt++;
      end
      check({tag, "_cv_end"}, 32'(countValidA), 32'd1);
      check({tag, "_cv_early"}, 32'(cvEarly), 32'd0);
      check({tag, "_count_hold"}, 32'(holdBad), 32'd0);
      check({tag, "_count"}, 32'(countA), 32'(expCount));
      check({tag, "_overflow"}, 32'(overflowA), 32'(expOvf));
      check({tag, "_bcdvalid_at"}, 32'(bvAt), BCD_ON ? 32'(CW_A) : 32'hffffffff);
      check({tag, "_bcdvalid_n"}, 32'(bvCnt), BCD_ON ? 32'd1 : 32'd0);
      check({tag, "_busy_n"}, 32'(busyCnt), BCD_ON ? 32'(CW_A) : 32'd0);
      check({tag, "_bcd"}, 32'(bcdA), BCD_ON ? toBcd(prevCount) : 32'd0);
   endtask

   int   n, bvAt, bvCnt, busyCnt;
   logic done;

   initial begin
      rstA = 1'b0; rstB = 1'b0; sigA = 1'b0; sigB = 1'b0;
      repeat (3) tick();
      check("rst_count", 32'(countA), 32'd0);
      check("rst_overflow", 32'(overflowA), 32'd0);
      check("rst_countvalid", 32'(countValidA), 32'd0);
      check("rst_bcd", 32'(bcdA), 32'd0);
      check("rst_bcdvalid", 32'(bcdValidA), 32'd0);
      check("rst_busy", 32'(busyA), 32'd0);

      rstA = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!countValidA && n < 2 * GATE_A);
      check("first_cv_latency", 32'(n), 32'(GATE_A));
      check("first_count", 32'(countA), 32'd0);

      runWindow("p10a",      10, 10, -1, 1'b0, 10, 1'b0, 0);
      runWindow("p10b",      10, 10, -1, 1'b0, 10, 1'b0, 10);
      runWindow("sat20",     20, 4,  -1, 1'b0, 15, 1'b1, 10);
      runWindow("after_sat", 3,  4,  -1, 1'b0, 3,  1'b0, 15);
      runWindow("term5",     4,  4,  97, 1'b0, 5,  1'b0, 3);
      runWindow("fresh",     0,  4,  -1, 1'b0, 0,  1'b0, 5);
      runWindow("term_sat",  15, 4,  97, 1'b0, 15, 1'b1, 0);
      runWindow("zero",      0,  4,  -1, 1'b0, 0,  1'b0, 15);
      runWindow("term_full", 14, 4,  97, 1'b0, 15, 1'b0, 0);
      runWindow("const_hi1", 0,  4,  -1, 1'b1, 0,  1'b0, 15);
      runWindow("const_hi2", 0,  4,  -1, 1'b1, 0,  1'b0, 0);
      runWindow("const_lo",  0,  4,  -1, 1'b0, 0,  1'b0, 0);
      runWindow("pre_reset", 3,  4,  -1, 1'b0, 3,  1'b0, 0);

      // Reset two cycles into a window, while the conversion of 3 is running.
      sigA = 1'b1; tick();
      sigA = 1'b1; tick();
      sigA = 1'b0; rstA = 1'b0; tick();
      rstA = 1'b1;
      check("midrst_count", 32'(countA), 32'd0);
      check("midrst_overflow", 32'(overflowA), 32'd0);
      check("midrst_countvalid", 32'(countValidA), 32'd0);
      check("midrst_bcd", 32'(bcdA), 32'd0);
      check("midrst_bcdvalid", 32'(bcdValidA), 32'd0);
      check("midrst_busy", 32'(busyA), 32'd0);
      n = 0; bvCnt = 0; busyCnt = 0;
      do begin
         sigA = (n < 28) && ((n % 4) < 2);
         tick();
         n++;
         if (bcdValidA) bvCnt++;
         if (busyA) busyCnt++;
      end while (!countValidA && n < 2 * GATE_A);
      check("midrst_cv_latency", 32'(n), 32'(GATE_A));
      check("midrst_count_after", 32'(countA), 32'd7);
      check("midrst_overflow_after", 32'(overflowA), 32'd0);
      check("midrst_no_bcdvalid", 32'(bvCnt), 32'd0);
      check("midrst_no_busy", 32'(busyCnt), 32'd0);
      runWindow("post_reset", 0, 4, -1, 1'b0, 0, 1'b0, 7);

      // 12345 edges at the fastest resolvable rate into the 16-bit instance.
      rstB = 1'b1;
      n = 0; done = 1'b0;
      while (!done && n < GATE_B + 100) begin
         sigB = (n < 12345 * 4) && ((n % 4) < 2);
         tick();
         n++;
         if (countValidB) done = 1'b1;
      end
      check("B_cv_latency", 32'(n), 32'(GATE_B));
      check("B_count", 32'(countB), 32'd12345);
      check("B_overflow", 32'(overflowB), 32'd0);
      bvAt = -1; bvCnt = 0; busyCnt = 0;
      for (int j = 0; j < 24; j++) begin
         sigB = 1'b0;
         tick();
         if (bcdValidB) begin
            bvCnt++;
            if (bvAt < 0) bvAt = j;
         end
         if (busyB) busyCnt++;
      end
      check("B_bcdvalid_at", 32'(bvAt), BCD_ON ? 32'd16 : 32'hffffffff);
      check("B_bcdvalid_n", 32'(bvCnt), BCD_ON ? 32'd1 : 32'd0);
      check("B_busy_n", 32'(busyCnt), BCD_ON ? 32'd16 : 32'd0);
      check("B_bcd", 32'(bcdB), BCD_ON ? 32'h12345 : 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
